pad_io_ctrl: RTL and testbench

PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

---
 rtl/pad_io_ctrl_pkg.sv | 18 +
 rtl/pad_in_filter.sv | 71 +++++++
 rtl/pad_io_ctrl.sv | 138 +++++++++++++
 tb/tb_pad_io_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_io_ctrl_pkg.sv
// Shared definitions for the pad I/O controller.
//   FILT_W_DEF / TA_CYC_DEF : parameter defaults used by pad_io_ctrl and pad_in_filter
//   TA_CNT_W                : turnaround down-counter width (covers TA_CYC 1..15)
//   dir_state_e             : direction FSM state encoding
package pad_io_ctrl_pkg;

    localparam int FILT_W_DEF = 4;
    localparam int TA_CYC_DEF = 2;
    localparam int TA_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IN     = 2'd0,
        ST_TA_OUT = 2'd1,
        ST_OUT    = 2'd2,
        ST_TA_IN  = 2'd3
    } dir_state_e;

endpackage

// File: rtl/pad_in_filter.sv
// Pad input path: 2-flop synchronizer, deglitch counter and edge detect.
//   clk, rst_n          : block clock, synchronous active-low reset
//   pad_c               : raw pad level, asynchronous to clk
//   filt_len            : deglitch length L; a new level must persist L+1 synchronized cycles
//   rx_data             : filtered level
//   rx_rise / rx_fall   : one-cycle pulses in the cycle rx_data changes
module pad_in_filter
    import pad_io_ctrl_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_c,
    input  logic [FILT_W-1:0] filt_len,
    output logic              rx_data,
    output logic              rx_rise,
    output logic              rx_fall
);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              rx_q, rx_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync1_d = pad_c;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == rx_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len) begin
            // >= rather than == so a shortened L mid-count still terminates
            // and the counter can never wrap.
            rx_d   = sync2_q;
            cnt_d  = '0;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            rx_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rx_data = rx_q;
    assign rx_rise = rise_q;
    assign rx_fall = fall_q;

endmodule

// File: rtl/pad_io_ctrl.sv
// Bidirectional pad controller: direction FSM with bus turnaround, pad drive
// and filtered pad receive path.
//   clk, rst_n                 : block clock, synchronous active-low reset
//   cfg_dir_vld / cfg_dir_out  : direction request strobe and direction (1=out)
//   cfg_dir_ack                : one-cycle completion pulse
//   busy                       : high during turnaround
//   tx_data                    : data to drive in output mode
//   cfg_pull_en, cfg_filt_len  : pull enable, deglitch length
//   rx_data, rx_rise, rx_fall  : filtered pad level and its edge pulses
//   pad_i, pad_oen, pad_ren    : pad cell drive (OEN/REN active-low)
//   pad_c                      : pad cell receive, asynchronous
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IN     | pad is input, OEN high, I low
// ST_TA_OUT | turnaround to output, OEN still high, I pre-driven
// ST_OUT    | pad drives tx_data (one-cycle delayed), OEN low
// ST_TA_IN  | turnaround to input, OEN high, I low
module pad_io_ctrl
    import pad_io_ctrl_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF,
    parameter int TA_CYC = TA_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_dir_vld,
    input  logic              cfg_dir_out,
    output logic              cfg_dir_ack,
    output logic              busy,
    input  logic              tx_data,
    input  logic              cfg_pull_en,
    input  logic [FILT_W-1:0] cfg_filt_len,
    output logic              rx_data,
    output logic              rx_rise,
    output logic              rx_fall,
    output logic              pad_i,
    output logic              pad_oen,
    output logic              pad_ren,
    input  logic              pad_c
);

    // Down-counter loaded on entry; leaving at zero gives exactly TA_CYC cycles.
    localparam logic [TA_CNT_W-1:0] TA_LOAD = TA_CNT_W'(TA_CYC - 1);

    dir_state_e          state_q, state_d;
    logic [TA_CNT_W-1:0] ta_cnt_q, ta_cnt_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                pad_i_q, pad_i_d;
    logic                pad_oen_q, pad_oen_d;
    logic                pad_ren_q, pad_ren_d;

    // State register (plus registered outputs)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IN;
            ta_cnt_q  <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            pad_i_q   <= 1'b0;
            pad_oen_q <= 1'b1;
            pad_ren_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ta_cnt_q  <= ta_cnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            pad_i_q   <= pad_i_d;
            pad_oen_q <= pad_oen_d;
            pad_ren_q <= pad_ren_d;
        end
    end

    // Next state; requests arriving during turnaround are dropped.
    always_comb begin
        state_d  = state_q;
        ta_cnt_d = ta_cnt_q;
        case (state_q)
            ST_IN: begin
                if (cfg_dir_vld && cfg_dir_out) begin
                    state_d  = ST_TA_OUT;
                    ta_cnt_d = TA_LOAD;
                end
            end
            ST_TA_OUT: begin
                if (ta_cnt_q == '0) state_d = ST_OUT;
                else                ta_cnt_d = ta_cnt_q - TA_CNT_W'(1);
            end
            ST_OUT: begin
                if (cfg_dir_vld && !cfg_dir_out) begin
                    state_d  = ST_TA_IN;
                    ta_cnt_d = TA_LOAD;
                end
            end
            ST_TA_IN: begin
                if (ta_cnt_q == '0) state_d = ST_IN;
                else                ta_cnt_d = ta_cnt_q - TA_CNT_W'(1);
            end
            default: state_d = ST_IN;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ack_d = 1'b0;
        if ((state_q == ST_TA_OUT || state_q == ST_TA_IN) && ta_cnt_q == '0) begin
            ack_d = 1'b1;
        end else if (cfg_dir_vld &&
                     ((state_q == ST_IN  && !cfg_dir_out) ||
                      (state_q == ST_OUT &&  cfg_dir_out))) begin
            ack_d = 1'b1;
        end
        busy_d    = (state_d == ST_TA_OUT) || (state_d == ST_TA_IN);
        pad_oen_d = (state_d != ST_OUT);
        pad_i_d   = ((state_d == ST_TA_OUT) || (state_d == ST_OUT)) ? tx_data : 1'b0;
        pad_ren_d = ~cfg_pull_en;
    end

    pad_in_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_c    (pad_c),
        .filt_len (cfg_filt_len),
        .rx_data  (rx_data),
        .rx_rise  (rx_rise),
        .rx_fall  (rx_fall)
    );

    assign cfg_dir_ack = ack_q;
    assign busy        = busy_q;
    assign pad_i       = pad_i_q;
    assign pad_oen     = pad_oen_q;
    assign pad_ren     = pad_ren_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Scoreboard bench for pad_io_ctrl: stimulus pushes expected acks and rx
// edges, a negedge monitor pops them when the DUT pulses.
module tb_pad_io_ctrl;

    localparam int FILT_W = 4;
    localparam int TA_CYC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cfg_dir_vld, cfg_dir_out, tx_data, cfg_pull_en, pad_c;
    logic [FILT_W-1:0] cfg_filt_len;
    logic              cfg_dir_ack, busy, rx_data, rx_rise, rx_fall, pad_i, pad_oen, pad_ren;

    pad_io_ctrl #(
        .FILT_W (FILT_W),
        .TA_CYC (TA_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_dir_vld  (cfg_dir_vld),
        .cfg_dir_out  (cfg_dir_out),
        .cfg_dir_ack  (cfg_dir_ack),
        .busy         (busy),
        .tx_data      (tx_data),
        .cfg_pull_en  (cfg_pull_en),
        .cfg_filt_len (cfg_filt_len),
        .rx_data      (rx_data),
        .rx_rise      (rx_rise),
        .rx_fall      (rx_fall),
        .pad_i        (pad_i),
        .pad_oen      (pad_oen),
        .pad_ren      (pad_ren),
        .pad_c        (pad_c)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        bit val;
    } exp_t;

    exp_t ack_q[$];
    exp_t edge_q[$];

    // Reference model: current transition window and direction, pad history.
    bit in_reset;
    int m_lo, m_hi;
    bit m_prev, m_tgt;
    bit hist[$];
    bit rx_model;
    int cur_l;
    bit pad_lvl;
    int run_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lo = -10;
        m_hi = -10;
        m_prev = 1'b0;
        m_tgt = 1'b0;
        rx_model = 1'b0;
        hist.delete();
        for (int k = 0; k < 16; k++) hist.push_back(1'b0);
        ack_q.delete();
        edge_q.delete();
    endtask

    // One clock of stimulus; the model predicts from the rules directly:
    // a request is honoured only outside a turnaround window, and rx takes a
    // new level once L+1 consecutive synchronized samples all show it.
    task automatic drive(input bit vld, input bit dir, input bit tx, input bit pull, input bit pad);
        exp_t e;
        bit   all_same;
        @(posedge clk);
        #1;
        cfg_dir_vld = vld;
        cfg_dir_out = dir;
        tx_data     = tx;
        cfg_pull_en = pull;
        pad_c       = pad;
        if (!in_reset) begin
            if (vld && cyc > m_hi) begin
                if (dir == m_tgt) begin
                    e.cyc = cyc + 1;
                end else begin
                    m_prev = m_tgt;
                    m_tgt  = dir;
                    m_lo   = cyc + 1;
                    m_hi   = cyc + TA_CYC;
                    e.cyc  = cyc + TA_CYC + 1;
                end
                e.val = dir;
                ack_q.push_back(e);
            end
            hist.push_front(pad);
            void'(hist.pop_back());
            all_same = 1'b1;
            for (int k = 0; k <= cur_l; k++) if (hist[k] != pad) all_same = 1'b0;
            if (all_same && pad != rx_model) begin
                rx_model = pad;
                e.cyc = cyc + 3;
                e.val = pad;
                edge_q.push_back(e);
            end
        end
    endtask

    task automatic set_len(input int l);
        cur_l = l;
        cfg_filt_len = FILT_W'(l);
    endtask

    // Monitor
    exp_t mon_e;
    bit   tx_prev, pull_prev;
    bit   mw, md, mo;

    always @(negedge clk) begin
        if (cfg_dir_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ack_unexpected cyc=%0d actual=1 required=0", cyc);
            end else begin
                mon_e = ack_q.pop_front();
                check("ack_cycle", cyc, mon_e.cyc);
                check("ack_oen", pad_oen, !mon_e.val);
            end
        end
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            mon_e = ack_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL ack_missing cyc=%0d actual=none required_at=%0d", cyc, mon_e.cyc);
        end
        if (rx_rise === 1'b1 || rx_fall === 1'b1) begin
            check("edge_both", rx_rise & rx_fall, 0);
            if (edge_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL edge_unexpected cyc=%0d actual_rise=%0b actual_fall=%0b required=none",
                         cyc, rx_rise, rx_fall);
            end else begin
                mon_e = edge_q.pop_front();
                check("edge_cycle", cyc, mon_e.cyc);
                check("edge_rise", rx_rise, mon_e.val);
                check("edge_rx_data", rx_data, mon_e.val);
            end
        end
        while (edge_q.size() > 0 && edge_q[0].cyc < cyc) begin
            mon_e = edge_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL edge_missing cyc=%0d actual=none required_at=%0d", cyc, mon_e.cyc);
        end
        if (!in_reset) begin
            mw = (cyc >= m_lo) && (cyc <= m_hi);
            md = (cyc > m_hi) ? m_tgt : m_prev;
            mo = mw ? m_tgt : md;
            check("busy", busy, mw);
            check("pad_oen", pad_oen, mw ? 1'b1 : !md);
            check("pad_i", pad_i, mo ? tx_prev : 1'b0);
            check("pad_ren", pad_ren, !pull_prev);
        end
        tx_prev   = tx_data;
        pull_prev = cfg_pull_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_reset = 1'b1;
        cfg_dir_vld = 1'b0;
        cfg_dir_out = 1'b0;
        tx_data = 1'b0;
        cfg_pull_en = 1'b1;
        pad_c = 1'b0;
        set_len(0);
        model_reset();
        tx_prev = 1'b0;
        pull_prev = 1'b1;
        pad_lvl = 1'b0;
        run_left = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pad_oen", pad_oen, 1);
        check("rst_pad_i", pad_i, 0);
        check("rst_pad_ren", pad_ren, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", cfg_dir_ack, 0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        model_reset();

        // Directed turnaround out and back, with requests during busy.
        set_len(3);
        drive(1, 1, 1, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 1, 1, 0);
        repeat (5) drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);

        // L=3: short pulse filtered, held level passes.
        repeat (3) drive(0, 0, 0, 0, 1);
        repeat (10) drive(0, 0, 0, 0, 0);
        repeat (12) drive(0, 0, 0, 0, 1);
        repeat (12) drive(0, 0, 0, 0, 0);

        // L=0: pad_c toggling every 4 cycles.
        set_len(0);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, bit'((i / 4) % 2));
        repeat (10) drive(0, 0, 0, 0, 0);

        // Randomized rounds with varying L.
        for (int r = 0; r < 6; r++) begin
            set_len($urandom_range(0, 6));
            for (int i = 0; i < 300; i++) begin
                if (run_left == 0) begin
                    pad_lvl  = ~pad_lvl;
                    run_left = $urandom_range(1, cur_l + 3);
                end
                run_left--;
                drive($urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
                      1'($urandom), pad_lvl);
            end
            repeat (20) drive(0, 0, 1'($urandom), 1'($urandom), pad_lvl);
        end

        // Reset during the first turnaround cycle aborts the request.
        pad_lvl = 1'b0;
        repeat (20) drive(0, 0, 0, 0, 0);
        if (m_tgt) begin
            drive(1, 0, 0, 0, 0);
            repeat (6) drive(0, 0, 0, 0, 0);
        end
        drive(1, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_reset = 1'b1;
        cfg_dir_vld = 1'b0;
        cfg_pull_en = 1'b1;
        ack_q.delete();
        edge_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ta_pad_oen", pad_oen, 1);
        check("rst_ta_busy", busy, 0);
        check("rst_ta_pad_i", pad_i, 0);
        check("rst_ta_ack", cfg_dir_ack, 0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        model_reset();
        repeat (8) drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (20) drive(0, 0, 0, 0, 0);

        check("ack_q_drained", ack_q.size(), 0);
        check("edge_q_drained", edge_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
